game_status_display: RTL
========================

GAME_STATUS_DISPLAY -- requirements
Module: game_status_display

Interface
REQ-001 Parameter N_CH, default 2: number of game channels, 1..8.
REQ-002 Parameter LED_W, default 16: LED bar width; LVL_W = clog2(LED_W+1).
REQ-003 Parameter DIGITS, default 4: number of 7-segment digits; DATA_W = 4*DIGITS.
REQ-004 Parameter SCAN_DIV, default 100000: clocks per digit-scan step, >=2.
REQ-005 Parameter BLINK_DIV, default 25000000: clocks per blink-phase toggle, >=2.
REQ-006 Port clk, input, 1: sole clock, all logic on its rising edge.
REQ-007 Port clr_n, input, 1: reset, asynchronous and active-low.
REQ-008 Port en, input, N_CH: per-channel game-running flags.
REQ-009 Port level, input, N_CH*LVL_W: per-channel LED fill levels, channel i at bits [i*LVL_W +: LVL_W].
REQ-010 Port value, input, N_CH*DATA_W: per-channel hex display words, channel i at bits [i*DATA_W +: DATA_W].
REQ-011 Port blank, input, 1: forces the 7-segment display dark.
REQ-012 Port an, output, DIGITS: digit anodes, active-low.
REQ-013 Port seg, output, 7: segments a..g, seg[6]=a, active-low.
REQ-014 Port led, output, LED_W: registered LED bar.
REQ-015 Port active_ch, output, 3: index of the displayed channel.
REQ-016 Port state, output, 2: encoding IDLE=0, PLAY=1, OVER=2.

Function
REQ-017 Active channel: the lowest index i with en[i]=1, evaluated every cycle.
REQ-018 FSM transition IDLE->PLAY: any en bit is 1.
REQ-019 FSM transition PLAY->PLAY: any en bit is 1; active_ch tracks the lowest enabled index, including a same-cycle handover between channels.
REQ-020 FSM transition PLAY->OVER: all en bits are 0; disp_word keeps the last PLAY value.
REQ-021 FSM transition OVER->PLAY: any en bit is 1.
REQ-022 FSM transition OVER->IDLE: blank=1 with en all 0.
REQ-023 disp_word register: in PLAY it loads value of the active channel every cycle, 1-cycle latency; in OVER it holds; in IDLE it is 0.
REQ-024 led in PLAY, with L = level of the active channel registered 1 cycle: the top min(L,LED_W) bits are set, filled from the MSB.
REQ-025 led in PLAY: L > LED_W gives all ones; L = 0 gives all zeros.
REQ-026 led in IDLE and OVER: 0.
REQ-027 Scan counter: counts 0..SCAN_DIV-1 and wraps to 0.
REQ-028 Digit index: advances by 1 when the scan counter wraps, and wraps from DIGITS-1 to 0.
REQ-029 Digit d drives an[d]=0 with all other anode bits 1; seg decodes nibble disp_word[4d+:4] as hex 0-F.
REQ-030 Blink phase in OVER: toggles every BLINK_DIV cycles; it is cleared to 0 on every entry to OVER.
REQ-031 Blink phase outside OVER: held at 0.
REQ-032 an = all ones and seg = 7'h7F when blank=1 in any state (the scan counter keeps running).
REQ-033 an = all ones and seg = 7'h7F when the blink phase is 1 in OVER.
REQ-034 blank has no effect on led, active_ch or disp_word.
REQ-035 en bits above the lowest enabled index are ignored.
REQ-036 active_ch holds its last value in IDLE and OVER.

Reset
REQ-037 While clr_n=0: state=IDLE, active_ch=0, disp_word=0, led=0, an=all ones, seg=7'h7F, all counters and the blink phase =0.
REQ-038 Reset mid-game aborts immediately; the FSM does not pass through OVER.
REQ-039 First rising edge after clr_n rises: scanning starts at digit 0; a set en moves the FSM to PLAY on that edge.

Verification
REQ-040 Directed scenarios run with N_CH=2, LED_W=16, DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
REQ-041 LED fill: en=01, level ch0=3 -> state=PLAY, led=16'hE000 one cycle later; level ch0=20 -> led=16'hFFFF.
REQ-042 Channel handover: en=11 then en=10, ch1 value=16'h1234 -> active_ch=1, disp_word=16'h1234 within 2 cycles, no visit to OVER.
REQ-043 Game end: ch0 value=16'h0042, en drops 01->00 -> OVER, led=0, display holds 0042 and goes dark for 8 cycles, lit for 8 cycles, repeating.
REQ-044 Scan order: PLAY with value 16'hABCD -> an cycles 1110,1101,1011,0111 every 4 clocks, seg shows D,C,B,A; blank=1 -> an=1111 with led unchanged.
REQ-045 Reset mid-game: clr_n pulsed low asynchronously during PLAY -> all outputs take their reset values before the next clock edge, and state=IDLE.

Source files
------------

// File: rtl/game_status_display.sv
// -----------------------------------------------------------------------------
// game_status_display
//   Status front panel for up to eight game channels. The lowest-numbered
//   running channel owns the display: its fill level drives the LED bar and
//   its hex word is scanned onto a multiplexed 7-segment display. When every
//   channel stops, the last word is held and blinks until blank clears the
//   panel back to idle.
//
// Ports
//   clk        : clock, rising edge
//   clr_n      : asynchronous active-low reset
//   en         : [N_CH] per-channel game-running flags
//   level      : [N_CH*LVL_W] per-channel LED fill levels
//   value      : [N_CH*DATA_W] per-channel hex display words
//   blank      : forces the 7-segment display dark
//   an         : [DIGITS] digit anodes, active-low
//   seg        : [7] segments a..g (seg[6]=a), active-low
//   led        : [LED_W] LED bar, filled from the MSB
//   active_ch  : [3] channel currently shown
//   state      : [2] IDLE=0, PLAY=1, OVER=2
// -----------------------------------------------------------------------------
module game_status_display #(
  parameter int N_CH      = 2,
  parameter int LED_W     = 16,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000,
  localparam int LVL_W    = $clog2(LED_W + 1),
  localparam int DATA_W   = 4 * DIGITS
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH*LVL_W-1:0]    level,
  input  logic [N_CH*DATA_W-1:0]   value,
  input  logic                     blank,
  output logic [DIGITS-1:0]        an,
  output logic [6:0]               seg,
  output logic [LED_W-1:0]         led,
  output logic [2:0]               active_ch,
  output logic [1:0]               state
);

  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  state_t               state_reg, state_next;
  logic [2:0]           active_ch_reg;
  logic [DATA_W-1:0]    disp_word_reg;
  logic [LED_W-1:0]     led_reg;
  logic [SCAN_W-1:0]    scan_cnt_reg;
  logic [DIG_W-1:0]     digit_reg;
  logic [BLINK_W-1:0]   blink_cnt_reg;
  logic                 blink_phase_reg;
  logic [DIGITS-1:0]    an_reg, an_next;
  logic [6:0]           seg_reg, seg_next;

  // Unpack the per-channel buses.
  logic [LVL_W-1:0]     lvl_arr [N_CH];
  logic [DATA_W-1:0]    val_arr [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign lvl_arr[gi] = level[gi*LVL_W +: LVL_W];
    assign val_arr[gi] = value[gi*DATA_W +: DATA_W];
  end

  // Lowest enabled channel wins; higher en bits are ignored.
  logic                 any_en;
  logic [2:0]           sel_idx;
  logic [LVL_W-1:0]     sel_lvl;
  logic [DATA_W-1:0]    sel_val;

  always_comb begin
    any_en  = 1'b0;
    sel_idx = '0;
    sel_lvl = '0;
    sel_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (en[i] && !any_en) begin
        any_en  = 1'b1;
        sel_idx = 3'(i);
        sel_lvl = lvl_arr[i];
        sel_val = val_arr[i];
      end
    end
  end

  // Thermometer fill from the MSB: bit gi is lit once the level reaches
  // LED_W-gi, so levels above LED_W saturate to all ones.
  logic [LED_W-1:0] fill;

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_fill
    assign fill[gi] = ({1'b0, sel_lvl} >= (LVL_W+1)'(LED_W - gi));
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_en) state_next = PLAY;
      PLAY:    if (!any_en) state_next = OVER;
      OVER: begin
        if (any_en)     state_next = PLAY;
        else if (blank) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (display drive) ----------------
  logic [3:0] nib;
  logic [6:0] seg_on;   // active-high abcdefg
  logic       dark;

  always_comb begin
    nib     = '0;
    an_next = '1;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_reg == DIG_W'(d)) begin
        nib        = disp_word_reg[d*4 +: 4];
        an_next[d] = 1'b0;
      end
    end
    case (nib)
      4'h0: seg_on = 7'h7E;
      4'h1: seg_on = 7'h30;
      4'h2: seg_on = 7'h6D;
      4'h3: seg_on = 7'h79;
      4'h4: seg_on = 7'h33;
      4'h5: seg_on = 7'h5B;
      4'h6: seg_on = 7'h5F;
      4'h7: seg_on = 7'h70;
      4'h8: seg_on = 7'h7F;
      4'h9: seg_on = 7'h7B;
      4'hA: seg_on = 7'h77;
      4'hB: seg_on = 7'h1F;
      4'hC: seg_on = 7'h4E;
      4'hD: seg_on = 7'h3D;
      4'hE: seg_on = 7'h4F;
      default: seg_on = 7'h47;
    endcase
    seg_next = ~seg_on;
    dark     = blank || ((state_reg == OVER) && blink_phase_reg);
    if (dark) begin
      an_next  = '1;
      seg_next = 7'h7F;
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      active_ch_reg <= '0;
      disp_word_reg <= '0;
      led_reg       <= '0;
    end else begin
      if (state_next == PLAY) begin
        active_ch_reg <= sel_idx;
        disp_word_reg <= sel_val;
        led_reg       <= fill;
      end else begin
        led_reg <= '0;
        // OVER keeps the last word on display; IDLE clears it.
        if (state_next == IDLE) disp_word_reg <= '0;
      end
    end
  end

  // Free-running digit scan.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      scan_cnt_reg <= '0;
      digit_reg    <= '0;
    end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      digit_reg    <= (digit_reg == DIG_W'(DIGITS - 1)) ? '0 : digit_reg + 1'b1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  // Blink phase restarts lit on each entry to OVER.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if ((state_reg == OVER) && (state_next == OVER)) begin
      if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end else begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end
  end

  // Registered display drive, dark during reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an_reg  <= '1;
      seg_reg <= 7'h7F;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign an        = an_reg;
  assign seg       = seg_reg;
  assign led       = led_reg;
  assign active_ch = active_ch_reg;
  assign state     = state_reg;

endmodule
